// File: rtl/fp_mem_pkg.sv
// Shared definitions for the FP/integer data-memory sequencer.
//   - seq_state_e : sequencer state encoding (IDLE, BEAT0, BEAT1, FINISH)
//   - STROBE_ON / STROBE_OFF : levels of the active-low SRAM strobes
//   - DEF_ADDR_W / DEF_TIMEOUT : default parameter values
//   - dp_misaligned() : double-precision accesses must start on an even word
package fp_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BEAT0  = 2'd1,
    BEAT1  = 2'd2,
    FINISH = 2'd3
  } seq_state_e;

  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  localparam int DEF_ADDR_W  = 7;
  localparam int DEF_TIMEOUT = 15;

  function automatic logic dp_misaligned(input logic dp, input logic addr_lsb);
    return dp & addr_lsb;
  endfunction

endpackage

// File: rtl/fp_dmem_timeout.sv
// Per-beat wait counter for the data-memory sequencer.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_clr       : return the count to zero (has priority)
//   i_en        : one more cycle spent waiting for the memory
//   o_expired   : this waiting cycle is the TIMEOUT-th one; the owner aborts
module fp_dmem_timeout
  import fp_mem_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  // The count never needs to hold TIMEOUT itself: the TIMEOUT-th waiting
  // cycle is flagged while the count still shows TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  assign o_expired = i_en && (r_count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !o_expired) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fp_dmem_sequencer.sv
// Multi-cycle owner of the data-memory port for the core's integer and FP
// load/store paths. Double-precision accesses are split into two 32-bit
// beats at A and A+1; each beat waits on mem_ready, bounded by TIMEOUT.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   req, req_store,
//   req_dp, req_addr,
//   req_wdata             : access request, sampled only in IDLE
//   stall                 : holds the core PC / register writes
//   rdata, rdata_valid    : load result {beat0, beat1} and its one-cycle pulse
//   fp_wr_beat            : 1 while the second beat (FP reg rt+1) is active
//   done, err             : completion / misalignment-or-timeout pulses
//   CEN, WEN, OEN, A,
//   Data2Mem              : registered SRAM-side controls (strobes active-low)
//   ReadDataMem, mem_ready: SRAM read data and beat-complete handshake
module fp_dmem_sequencer
  import fp_mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              req_store,
  input  logic              req_dp,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              stall,
  output logic [63:0]       rdata,
  output logic              rdata_valid,
  output logic              fp_wr_beat,
  output logic              done,
  output logic              err,
  output logic              CEN,
  output logic              WEN,
  output logic              OEN,
  output logic [ADDR_W-1:0] A,
  output logic [31:0]       Data2Mem,
  input  logic [31:0]       ReadDataMem,
  input  logic              mem_ready
);

  seq_state_e        r_state;
  logic              r_store;
  logic              r_dp;
  logic [ADDR_W-1:0] r_addr;
  logic [63:0]       r_wdata;

  logic w_busy;
  logic w_cnt_en;
  logic w_cnt_clr;
  logic w_expired;

  assign w_busy    = (r_state == BEAT0) || (r_state == BEAT1);
  // Count only cycles spent waiting inside a beat; a completed beat or any
  // non-beat state starts the next beat from zero.
  assign w_cnt_en  = w_busy && !mem_ready;
  assign w_cnt_clr = !w_busy || mem_ready;

  // The request cycle itself must already freeze the PC, hence the
  // combinational term on req in IDLE.
  assign stall = w_busy || ((r_state == IDLE) && req);

  fp_dmem_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_cnt_clr),
    .i_en      (w_cnt_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_store     <= 1'b0;
      r_dp        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      fp_wr_beat  <= 1'b0;
      CEN         <= STROBE_OFF;
      WEN         <= STROBE_OFF;
      OEN         <= STROBE_OFF;
      A           <= '0;
      Data2Mem    <= '0;
    end else begin
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req) begin
            if (dp_misaligned(req_dp, req_addr[0])) begin
              err <= 1'b1;
            end else begin
              r_state <= BEAT0;
              r_store <= req_store;
              r_dp    <= req_dp;
              r_addr  <= req_addr;
              r_wdata <= req_wdata;
              CEN     <= STROBE_ON;
              A       <= req_addr;
              WEN     <= req_store ? STROBE_ON  : STROBE_OFF;
              OEN     <= req_store ? STROBE_OFF : STROBE_ON;
              if (req_store) Data2Mem <= req_wdata[63:32];
            end
          end
        end

        BEAT0: begin
          if (mem_ready) begin
            // Writing the low half as zero here is what leaves single-word
            // load results zero-extended on the right.
            if (!r_store) rdata <= {ReadDataMem, 32'h0};
            if (r_dp) begin
              r_state    <= BEAT1;
              A          <= r_addr + ADDR_W'(1);
              fp_wr_beat <= 1'b1;
              if (r_store) Data2Mem <= r_wdata[31:0];
            end else begin
              r_state     <= FINISH;
              CEN         <= STROBE_OFF;
              WEN         <= STROBE_OFF;
              OEN         <= STROBE_OFF;
              done        <= 1'b1;
              rdata_valid <= !r_store;
            end
          end else if (w_expired) begin
            r_state <= IDLE;
            CEN     <= STROBE_OFF;
            WEN     <= STROBE_OFF;
            OEN     <= STROBE_OFF;
            err     <= 1'b1;
          end
        end

        BEAT1: begin
          if (mem_ready) begin
            if (!r_store) rdata[31:0] <= ReadDataMem;
            r_state     <= FINISH;
            CEN         <= STROBE_OFF;
            WEN         <= STROBE_OFF;
            OEN         <= STROBE_OFF;
            fp_wr_beat  <= 1'b0;
            done        <= 1'b1;
            rdata_valid <= !r_store;
          end else if (w_expired) begin
            r_state    <= IDLE;
            CEN        <= STROBE_OFF;
            WEN        <= STROBE_OFF;
            OEN        <= STROBE_OFF;
            fp_wr_beat <= 1'b0;
            err        <= 1'b1;
          end
        end

        FINISH: begin
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_dmem_sequencer.sv
module tb_fp_dmem_sequencer;

  localparam int AW = 7;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic          req_store = 1'b0;
  logic          req_dp = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [63:0]   req_wdata = '0;
  logic          stall;
  logic [63:0]   rdata;
  logic          rdata_valid;
  logic          fp_wr_beat;
  logic          done;
  logic          err;
  logic          CEN;
  logic          WEN;
  logic          OEN;
  logic [AW-1:0] A;
  logic [31:0]   Data2Mem;
  logic [31:0]   ReadDataMem;
  logic          mem_ready;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fp_dmem_sequencer #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_store   (req_store),
    .req_dp      (req_dp),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .stall       (stall),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .fp_wr_beat  (fp_wr_beat),
    .done        (done),
    .err         (err),
    .CEN         (CEN),
    .WEN         (WEN),
    .OEN         (OEN),
    .A           (A),
    .Data2Mem    (Data2Mem),
    .ReadDataMem (ReadDataMem),
    .mem_ready   (mem_ready)
  );

  // ---------------- SRAM model with programmable per-beat latency ----------
  logic [31:0] mem [128];
  logic [31:0] ref_mem [128];
  int  lat0 = 0;
  int  lat1 = 0;
  int  wait_cnt = 0;
  bit  beat_i = 1'b0;
  bit  noise = 1'b0;
  bit  mem_init = 1'b0;

  assign mem_ready   = ((CEN == 1'b0) && (wait_cnt >= (beat_i ? lat1 : lat0))) || noise;
  assign ReadDataMem = mem[A];

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'hC0DE_0000 + 32'(i);
      mem_init <= 1'b1;
    end else if (CEN) begin
      wait_cnt <= 0;
      beat_i   <= 1'b0;
    end else if (mem_ready) begin
      wait_cnt <= 0;
      beat_i   <= 1'b1;
      if (!WEN) mem[A] <= Data2Mem;
    end else begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  // ---------------- transaction driver / observer --------------------------
  int            m_cycles, m_done, m_err, m_valid, m_stall_bad, m_idle_bad;
  logic          m_req_stall;
  logic [63:0]   m_rdata;
  bit            m_seen [2];
  logic [AW-1:0] m_a [2];
  logic          m_we [2];
  logic          m_oe [2];
  logic          m_fp [2];
  logic [31:0]   m_d [2];

  task automatic run_txn(input bit st, input bit dp, input logic [AW-1:0] addr,
                         input logic [63:0] wd, input int l0, input int l1);
    bit fin;
    m_cycles = 0; m_done = 0; m_err = 0; m_valid = 0; m_stall_bad = 0; m_idle_bad = 0;
    m_rdata = '0; m_seen[0] = 0; m_seen[1] = 0;
    @(negedge clk);
    lat0 = l0; lat1 = l1;
    req = 1'b1; req_store = st; req_dp = dp; req_addr = addr; req_wdata = wd;
    #1 m_req_stall = stall;
    fin = 0;
    for (int c = 1; c <= 60 && !fin; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req = 1'b0; req_store = 1'($urandom); req_dp = 1'($urandom);
        req_addr = AW'($urandom); req_wdata = {$urandom, $urandom};
      end
      #1;
      if (!CEN && !m_seen[beat_i]) begin
        m_seen[beat_i] = 1; m_a[beat_i] = A; m_we[beat_i] = WEN;
        m_oe[beat_i] = OEN; m_fp[beat_i] = fp_wr_beat; m_d[beat_i] = Data2Mem;
      end
      if (done) m_done++;
      if (err) m_err++;
      if (rdata_valid) begin m_valid++; m_rdata = rdata; end
      if (done || err) begin
        fin = 1; m_cycles = c;
        if (stall !== 1'b0) m_stall_bad++;
      end else if (stall !== 1'b1) m_stall_bad++;
    end
    @(negedge clk); #1;
    if (done) m_done++;
    if (err) m_err++;
    if (rdata_valid) m_valid++;
    if (CEN !== 1'b1 || WEN !== 1'b1 || OEN !== 1'b1 || stall !== 1'b0) m_idle_bad++;
  endtask

  // Specification-level expectation for one access; also applies completed
  // store beats to the reference memory image.
  task automatic model(input bit st, input bit dp, input logic [AW-1:0] addr,
                       input logic [63:0] wd, input int l0, input int l1,
                       output int e_cycles, output int e_done, output int e_err,
                       output int e_valid, output logic [63:0] e_rdata, output int e_beats);
    logic [AW-1:0] a1;
    a1 = addr + AW'(1);
    e_done = 0; e_err = 0; e_valid = 0; e_rdata = '0;
    if (dp && addr[0]) begin
      e_err = 1; e_cycles = 1; e_beats = 0;
    end else if (l0 >= TO) begin
      e_err = 1; e_cycles = TO + 1; e_beats = 1;
    end else if (dp && l1 >= TO) begin
      e_err = 1; e_cycles = l0 + 1 + TO + 1; e_beats = 2;
      if (st) ref_mem[addr] = wd[63:32];
    end else begin
      e_done = 1;
      e_cycles = dp ? (l0 + l1 + 3) : (l0 + 2);
      e_beats = dp ? 2 : 1;
      e_valid = st ? 0 : 1;
      e_rdata = {ref_mem[addr], dp ? ref_mem[a1] : 32'h0};
      if (st) begin
        ref_mem[addr] = wd[63:32];
        if (dp) ref_mem[a1] = wd[31:0];
      end
    end
  endtask

  // ---------------- scenarios ----------------------------------------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({CEN, WEN, OEN} !== 3'b111) begin
      n_errors++; $display("FAIL reset_strobes: got %b expected 111", {CEN, WEN, OEN});
    end
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if ({stall, rdata_valid, done, err, fp_wr_beat} !== 5'b0) begin
      n_errors++; $display("FAIL reset_ctrl: got %b expected 00000", {stall, rdata_valid, done, err, fp_wr_beat});
    end
    n_checks++;
    if (rdata !== 64'h0 || A !== '0 || Data2Mem !== 32'h0) begin
      n_errors++; $display("FAIL reset_data: got rdata=%h A=%h D=%h expected zeros", rdata, A, Data2Mem);
    end
  endtask

  task automatic test_single_load();
    int ec, ed, ee, ev, eb; logic [63:0] er;
    model(1, 0, 7'd10, 64'hDEADBEEF_5555AAAA, 0, 0, ec, ed, ee, ev, er, eb);
    run_txn(1, 0, 7'd10, 64'hDEADBEEF_5555AAAA, 0, 0);
    model(0, 0, 7'd10, 64'h0, 0, 0, ec, ed, ee, ev, er, eb);
    run_txn(0, 0, 7'd10, 64'h0, 0, 0);
    n_checks++;
    if (m_req_stall !== 1'b1) begin
      n_errors++; $display("FAIL sl_req_stall: got %b expected 1", m_req_stall);
    end
    n_checks++;
    if (!m_seen[0] || m_a[0] !== 7'd10 || m_oe[0] !== 1'b0 || m_we[0] !== 1'b1) begin
      n_errors++; $display("FAIL sl_beat0: got A=%0d OEN=%b WEN=%b expected A=10 OEN=0 WEN=1", m_a[0], m_oe[0], m_we[0]);
    end
    n_checks++;
    if (m_cycles !== 2 || m_done !== 1 || m_valid !== 1 || m_stall_bad !== 0) begin
      n_errors++; $display("FAIL sl_timing: got cyc=%0d done=%0d valid=%0d stallbad=%0d expected 2 1 1 0", m_cycles, m_done, m_valid, m_stall_bad);
    end
    n_checks++;
    if (m_rdata !== 64'hDEADBEEF_00000000) begin
      n_errors++; $display("FAIL sl_rdata: got %h expected DEADBEEF00000000", m_rdata);
    end
  endtask

  task automatic test_dp_store();
    int ec, ed, ee, ev, eb; logic [63:0] er;
    model(1, 1, 7'd20, 64'h11112222_33334444, 0, 0, ec, ed, ee, ev, er, eb);
    run_txn(1, 1, 7'd20, 64'h11112222_33334444, 0, 0);
    n_checks++;
    if (m_we[0] !== 1'b0 || m_a[0] !== 7'd20 || m_d[0] !== 32'h11112222 || m_fp[0] !== 1'b0) begin
      n_errors++; $display("FAIL ds_beat0: got WEN=%b A=%0d D=%h fp=%b expected 0 20 11112222 0", m_we[0], m_a[0], m_d[0], m_fp[0]);
    end
    n_checks++;
    if (!m_seen[1] || m_a[1] !== 7'd21 || m_d[1] !== 32'h33334444 || m_fp[1] !== 1'b1) begin
      n_errors++; $display("FAIL ds_beat1: got A=%0d D=%h fp=%b expected 21 33334444 1", m_a[1], m_d[1], m_fp[1]);
    end
    n_checks++;
    if (m_cycles !== 3 || m_done !== 1 || m_valid !== 0) begin
      n_errors++; $display("FAIL ds_done: got cyc=%0d done=%0d valid=%0d expected 3 1 0", m_cycles, m_done, m_valid);
    end
    n_checks++;
    if (mem[20] !== 32'h11112222 || mem[21] !== 32'h33334444) begin
      n_errors++; $display("FAIL ds_mem: got %h %h expected 11112222 33334444", mem[20], mem[21]);
    end
  endtask

  task automatic test_dp_load_top();
    int ec, ed, ee, ev, eb; logic [63:0] er;
    model(1, 1, 7'd126, 64'h0000000A_0000000B, 1, 2, ec, ed, ee, ev, er, eb);
    run_txn(1, 1, 7'd126, 64'h0000000A_0000000B, 1, 2);
    model(0, 1, 7'd126, 64'h0, 3, 3, ec, ed, ee, ev, er, eb);
    run_txn(0, 1, 7'd126, 64'h0, 3, 3);
    n_checks++;
    if (m_rdata !== 64'h0000000A_0000000B || m_valid !== 1) begin
      n_errors++; $display("FAIL dl_rdata: got %h valid=%0d expected 0000000A0000000B 1", m_rdata, m_valid);
    end
    n_checks++;
    if (m_stall_bad !== 0 || m_cycles !== 9 || m_a[1] !== 7'd127) begin
      n_errors++; $display("FAIL dl_stall: got stallbad=%0d cyc=%0d A1=%0d expected 0 9 127", m_stall_bad, m_cycles, m_a[1]);
    end
  endtask

  task automatic test_misaligned();
    run_txn(0, 1, 7'd5, 64'h0, 0, 0);
    n_checks++;
    if (m_err !== 1 || m_done !== 0 || m_cycles !== 1) begin
      n_errors++; $display("FAIL mis_err: got err=%0d done=%0d cyc=%0d expected 1 0 1", m_err, m_done, m_cycles);
    end
    n_checks++;
    if (m_seen[0] || m_seen[1] || m_idle_bad !== 0) begin
      n_errors++; $display("FAIL mis_cen: got seen=%b%b idlebad=%0d expected 00 0", m_seen[0], m_seen[1], m_idle_bad);
    end
  endtask

  task automatic test_timeout();
    int ec, ed, ee, ev, eb; logic [63:0] er;
    run_txn(0, 0, 7'd33, 64'h0, 100, 0);
    n_checks++;
    if (m_err !== 1 || m_cycles !== TO + 1 || m_valid !== 0 || m_done !== 0) begin
      n_errors++; $display("FAIL to_beat0: got err=%0d cyc=%0d valid=%0d done=%0d expected 1 %0d 0 0", m_err, m_cycles, m_valid, m_done, TO + 1);
    end
    n_checks++;
    if (m_idle_bad !== 0) begin
      n_errors++; $display("FAIL to_strobes: got idlebad=%0d expected 0", m_idle_bad);
    end
    model(1, 1, 7'd50, 64'hAAAA5555_BBBB6666, 2, 40, ec, ed, ee, ev, er, eb);
    run_txn(1, 1, 7'd50, 64'hAAAA5555_BBBB6666, 2, 40);
    n_checks++;
    if (m_err !== ee || m_cycles !== ec || m_done !== 0) begin
      n_errors++; $display("FAIL to_beat1: got err=%0d cyc=%0d done=%0d expected %0d %0d 0", m_err, m_cycles, m_done, ee, ec);
    end
    n_checks++;
    if (mem[50] !== ref_mem[50] || mem[51] !== ref_mem[51]) begin
      n_errors++; $display("FAIL to_mem: got %h %h expected %h %h", mem[50], mem[51], ref_mem[50], ref_mem[51]);
    end
  endtask

  task automatic test_ignored_ready();
    int bad;
    bad = 0;
    @(negedge clk);
    noise = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      if (CEN !== 1'b1 || done !== 1'b0 || rdata_valid !== 1'b0 || stall !== 1'b0) bad++;
    end
    noise = 1'b0;
    n_checks++;
    if (bad !== 0) begin
      n_errors++; $display("FAIL idle_ready: got %0d disturbed cycles expected 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    int ec, ed, ee, ev, eb; logic [63:0] er;
    logic [63:0] wd;
    bit hit;
    wd = {$urandom, $urandom};
    @(negedge clk);
    lat0 = 0; lat1 = 10;
    req = 1'b1; req_store = 1'b1; req_dp = 1'b1; req_addr = 7'd40; req_wdata = wd;
    @(negedge clk);
    req = 1'b0;
    hit = 0;
    for (int c = 0; c < 12 && !hit; c++) begin
      #1;
      if (!CEN && A == 7'd41) hit = 1;
      else @(negedge clk);
    end
    n_checks++;
    if (!hit) begin
      n_errors++; $display("FAIL rm_reach_beat1: got no beat1 expected beat1 at A=41");
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (CEN !== 1'b1 || WEN !== 1'b1 || OEN !== 1'b1 || stall !== 1'b0 || fp_wr_beat !== 1'b0) begin
      n_errors++; $display("FAIL rm_strobes: got CEN=%b WEN=%b OEN=%b stall=%b fp=%b expected 1 1 1 0 0", CEN, WEN, OEN, stall, fp_wr_beat);
    end
    ref_mem[40] = wd[63:32];
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model(0, 0, 7'd40, 64'h0, 1, 0, ec, ed, ee, ev, er, eb);
    run_txn(0, 0, 7'd40, 64'h0, 1, 0);
    n_checks++;
    if (m_done !== 1 || m_valid !== 1 || m_rdata !== er || m_cycles !== ec) begin
      n_errors++; $display("FAIL rm_after: got done=%0d valid=%0d rdata=%h cyc=%0d expected 1 1 %h %0d", m_done, m_valid, m_rdata, m_cycles, er, ec);
    end
    n_checks++;
    if (mem[41] !== ref_mem[41]) begin
      n_errors++; $display("FAIL rm_discard: got %h expected %h", mem[41], ref_mem[41]);
    end
  endtask

  task automatic test_random();
    int ec, ed, ee, ev, eb, l0, l1, beats;
    logic [63:0] er, wd;
    logic [AW-1:0] addr, a1;
    bit st, dp, ok;
    for (int i = 0; i < 40; i++) begin
      st = 1'($urandom); dp = 1'($urandom);
      addr = AW'($urandom);
      if (dp && ($urandom_range(5) != 0)) addr[0] = 1'b0;
      a1 = addr + AW'(1);
      wd = {$urandom, $urandom};
      l0 = ($urandom_range(9) == 0) ? TO + int'($urandom_range(2)) : int'($urandom_range(3));
      l1 = ($urandom_range(9) == 0) ? TO + int'($urandom_range(2)) : int'($urandom_range(3));
      model(st, dp, addr, wd, l0, l1, ec, ed, ee, ev, er, eb);
      run_txn(st, dp, addr, wd, l0, l1);
      beats = int'(m_seen[0]) + int'(m_seen[1]);
      n_checks++;
      if (m_cycles !== ec || m_done !== ed || m_err !== ee || m_valid !== ev || beats !== eb) begin
        n_errors++;
        $display("FAIL rand%0d_flow: got cyc=%0d done=%0d err=%0d valid=%0d beats=%0d expected %0d %0d %0d %0d %0d",
                 i, m_cycles, m_done, m_err, m_valid, beats, ec, ed, ee, ev, eb);
      end
      n_checks++;
      if (ev == 1 && m_rdata !== er) begin
        n_errors++; $display("FAIL rand%0d_rdata: got %h expected %h", i, m_rdata, er);
      end
      ok = 1;
      if (m_seen[0] && (m_a[0] !== addr || m_we[0] !== !st || m_oe[0] !== st || m_fp[0] !== 1'b0 ||
                        (st && m_d[0] !== wd[63:32]))) ok = 0;
      if (m_seen[1] && (m_a[1] !== a1 || m_we[1] !== !st || m_oe[1] !== st || m_fp[1] !== 1'b1 ||
                        (st && m_d[1] !== wd[31:0]))) ok = 0;
      n_checks++;
      if (!ok) begin
        n_errors++; $display("FAIL rand%0d_beats: got A0=%0d A1=%0d D0=%h D1=%h expected A0=%0d A1=%0d st=%b wd=%h",
                             i, m_a[0], m_a[1], m_d[0], m_d[1], addr, a1, st, wd);
      end
      n_checks++;
      if (m_stall_bad !== 0 || m_idle_bad !== 0 || m_req_stall !== 1'b1) begin
        n_errors++; $display("FAIL rand%0d_stall: got stallbad=%0d idlebad=%0d reqstall=%b expected 0 0 1", i, m_stall_bad, m_idle_bad, m_req_stall);
      end
      n_checks++;
      if (mem[addr] !== ref_mem[addr] || mem[a1] !== ref_mem[a1]) begin
        n_errors++; $display("FAIL rand%0d_mem: got %h %h expected %h %h", i, mem[addr], mem[a1], ref_mem[addr], ref_mem[a1]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) ref_mem[i] = 32'hC0DE_0000 + 32'(i);
    test_reset();
    test_single_load();
    test_dp_store();
    test_dp_load_top();
    test_misaligned();
    test_timeout();
    test_ignored_ready();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fp_dmem_sequencer.md
Name: fp_dmem_sequencer

Overview:
- Multi-cycle sequencer that owns the data-memory port on behalf of the single-cycle core's integer and FP load/store paths.
- Splits each double-precision FP access (ldc1/sdc1) into two 32-bit beats at A and A+1.
- Waits on a variable-latency memory ready handshake and holds the core PC via a stall signal until the access completes.
- Sits between the core control/datapath and the SRAM-style data memory; replaces the core's ad hoc second-stage address/register increment.

Parameters:
- ADDR_W, 7, data-memory word address width
- TIMEOUT, 15, max cycles waited for mem_ready per beat before the access is aborted with err

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- req  in  1  access request from core control; sampled in IDLE only
- req_store  in  1  1 = store, 0 = load
- req_dp  in  1  1 = double-precision (two beats), 0 = single word
- req_addr  in  ADDR_W  word address of first beat
- req_wdata  in  64  store data; single-word stores use [63:32]
- stall  out  1  holds core PC/register writes while high
- rdata  out  64  load result; beat0 in [63:32], beat1 in [31:0]
- rdata_valid  out  1  one-cycle pulse, load result valid
- fp_wr_beat  out  1  0 = write FP reg rt, 1 = write rt+1 (for the core's FP regfile index)
- done  out  1  one-cycle pulse at completion (load or store)
- err  out  1  one-cycle pulse on misalignment or timeout
- CEN  out  1  memory chip enable, active-low
- WEN  out  1  memory write enable, active-low
- OEN  out  1  memory output enable, active-low
- A  out  ADDR_W  memory word address
- Data2Mem  out  32  memory write data
- ReadDataMem  in  32  memory read data
- mem_ready  in  1  memory beat complete (read data valid / write accepted)

Behaviour:
- Reset (async, rst_n low): state IDLE; stall=0, rdata=0, rdata_valid=0, done=0, err=0, fp_wr_beat=0; CEN=WEN=OEN=1; A=0; Data2Mem=0; timeout counter=0.
- States: IDLE, BEAT0, BEAT1, FINISH.
- IDLE:
  - req=1 with req_dp=1 and req_addr[0]=1: pulse err next cycle, stay IDLE, no memory access (misaligned dp).
  - Otherwise req=1: latch store/dp/addr/wdata, go to BEAT0.
  - stall is combinationally high in the same cycle req=1 is seen in IDLE, so the PC does not advance.
- BEAT0:
  - CEN=0, A=addr.
  - Load: OEN=0, WEN=1. Store: WEN=0, OEN=1, Data2Mem=wdata[63:32].
  - Counter increments each cycle while mem_ready=0.
  - On mem_ready=1: a load captures ReadDataMem into rdata[63:32]; counter clears; go to BEAT1 if dp, else FINISH.
- BEAT1:
  - A=addr+1, computed mod 2^ADDR_W; this cannot wrap given the even-address rule.
  - Store: Data2Mem=wdata[31:0]. fp_wr_beat=1.
  - On mem_ready=1: a load captures rdata[31:0]; go to FINISH.
- Timeout: counter reaching TIMEOUT in BEAT0/BEAT1 aborts. Pulse err, CEN/WEN/OEN deassert, return to IDLE with no done and no rdata_valid.
- FINISH (one cycle):
  - CEN/WEN/OEN=1, done=1, rdata_valid=1 for loads, stall=0.
  - Go to IDLE; a new req is accepted from the next cycle.
- Single-word loads leave rdata[31:0]=0.
- stall=1 in BEAT0 and BEAT1; 0 in FINISH and in IDLE without req.
- mem_ready outside BEAT0/BEAT1 is ignored.
- Request fields are ignored while busy; the core holds them because it is stalled.
- Reset mid-access: immediate return to IDLE with all memory strobes deasserted; the partial access is discarded.
- Minimum latency with mem_ready tied 1:
  - single word: request cycle plus 2 cycles to done (BEAT0, FINISH)
  - double: request cycle plus 3 cycles (BEAT0, BEAT1, FINISH)

Decomposition:
- Shared package fp_mem_pkg:
  - state encoding constants (IDLE=2'd0, BEAT0=2'd1, BEAT1=2'd2, FINISH=2'd3)
  - active-low strobe constants
  - default ADDR_W/TIMEOUT values
- One natural sub-module, fp_dmem_timeout: cycle counter with clear/enable/expired, parameterised by TIMEOUT.
- Everything else stays in one FSM module.

Test Plan:
- Single-word load, req_addr=7'd10, mem_ready=1, ReadDataMem=32'hDEADBEEF:
  - A=10, OEN=0, CEN=0 for one cycle.
  - Next cycle rdata=64'hDEADBEEF_00000000, rdata_valid=1, done=1, stall=0.
- DP store, req_addr=7'd20, req_wdata=64'h11112222_33334444, mem_ready=1:
  - WEN=0, A=20, Data2Mem=32'h11112222.
  - Then A=21, Data2Mem=32'h33334444, fp_wr_beat=1.
  - Then done=1.
- DP load, req_addr=7'd126, mem_ready low 3 cycles per beat, reads 32'hA, 32'hB:
  - stall high throughout.
  - rdata=64'h0000000A_0000000B, rdata_valid pulses once.
- DP load, req_addr=7'd5: err pulses once, CEN stays 1, no done.
- Load with mem_ready held 0, TIMEOUT=15: after 15 BEAT0 cycles err=1, strobes deassert, state IDLE, no rdata_valid.
- rst_n asserted low during BEAT1 of a dp store: CEN/WEN immediately 1, stall=0; a subsequent load completes normally.
